multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle processor control unit: fetch/decode/execute sequencer with
// memory handshake. Outputs are decoded combinationally from the current
// state, the opcode and the zero / mem_ready inputs; only the state is held
// in a register.
//
// state  | meaning
// -------+-------------------------------------------------------------
// FETCH  | 0  read instruction at PC, load IR and PC+4 on mem_ready
// DECODE | 1  register read, branch target into ALUOut
// MEMADR | 2  effective address for LW/SW
// MEMRD  | 3  data read at ALUOut, wait for mem_ready
// MEMWB  | 4  memory data into rt
// MEMWR  | 5  data write at ALUOut, wait for mem_ready
// REXEC  | 6  R-type ALU operation
// IEXEC  | 7  ADDI/SUBI ALU operation
// ALUWB  | 8  ALUOut into rd (R-type) or rt (immediate)
// BRANCH | 9  compare A and B, conditional PC load from ALUOut
// JUMP   | A  PC load from jump target
// JAL    | B  PC load from jump target, link PC into r31
// HALT   | F  illegal opcode seen, stuck until reset
module multicycle_ctrl (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [4:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       pcen,
    output logic [1:0] pcsrc,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic       regwrite,
    output logic [1:0] regdst,
    output logic [1:0] wbsel,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'h0,
        S_DECODE = 4'h1,
        S_MEMADR = 4'h2,
        S_MEMRD  = 4'h3,
        S_MEMWB  = 4'h4,
        S_MEMWR  = 4'h5,
        S_REXEC  = 4'h6,
        S_IEXEC  = 4'h7,
        S_ALUWB  = 4'h8,
        S_BRANCH = 4'h9,
        S_JUMP   = 4'hA,
        S_JAL    = 4'hB,
        S_HALT   = 4'hF
    } state_t;

    localparam logic [4:0] OP_ADDI = 5'b11000;
    localparam logic [4:0] OP_SUBI = 5'b11001;
    localparam logic [4:0] OP_LW   = 5'b11010;
    localparam logic [4:0] OP_SW   = 5'b11011;
    localparam logic [4:0] OP_BEQ  = 5'b11100;
    localparam logic [4:0] OP_BNE  = 5'b11101;
    localparam logic [4:0] OP_J    = 5'b00000;
    localparam logic [4:0] OP_JAL  = 5'b00111;

    state_t cur;
    state_t nxt;

    logic is_addi, is_subi, is_lw, is_sw, is_beq, is_bne, is_j, is_jal, is_rtype;

    assign is_addi  = (op == OP_ADDI);
    assign is_subi  = (op == OP_SUBI);
    assign is_lw    = (op == OP_LW);
    assign is_sw    = (op == OP_SW);
    assign is_beq   = (op == OP_BEQ);
    assign is_bne   = (op == OP_BNE);
    assign is_j     = (op == OP_J);
    assign is_jal   = (op == OP_JAL);
    assign is_rtype = (op[4:3] == 2'b01);

    assign state = cur;

    // Next-state selection; memory states advance only on mem_ready.
    always_comb begin
        nxt = cur;
        case (cur)
            S_FETCH:  nxt = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (is_lw || is_sw)          nxt = S_MEMADR;
                else if (is_addi || is_subi) nxt = S_IEXEC;
                else if (is_rtype)           nxt = S_REXEC;
                else if (is_beq || is_bne)   nxt = S_BRANCH;
                else if (is_j)               nxt = S_JUMP;
                else if (is_jal)             nxt = S_JAL;
                else                         nxt = S_HALT;
            end
            // op is stable here, so the fallback to FETCH is unreachable
            S_MEMADR: nxt = is_lw ? S_MEMRD : (is_sw ? S_MEMWR : S_FETCH);
            S_MEMRD:  nxt = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  nxt = mem_ready ? S_FETCH : S_MEMWR;
            S_REXEC:  nxt = S_ALUWB;
            S_IEXEC:  nxt = S_ALUWB;
            S_MEMWB:  nxt = S_FETCH;
            S_ALUWB:  nxt = S_FETCH;
            S_BRANCH: nxt = S_FETCH;
            S_JUMP:   nxt = S_FETCH;
            S_JAL:    nxt = S_FETCH;
            S_HALT:   nxt = S_HALT;
            default:  nxt = S_FETCH;
        endcase
    end

    // State register with synchronous reset back to FETCH.
    always_ff @(posedge clk) begin
        if (!reset_n) cur <= S_FETCH;
        else          cur <= nxt;
    end

    // Datapath controls per state; strobes are forced low while reset is held
    // so an access in flight is abandoned without a write or PC update.
    always_comb begin
        mem_req  = 1'b0;
        iord     = 1'b0;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        pcen     = 1'b0;
        pcsrc    = 2'b00;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        aluop    = 2'b00;
        regwrite = 1'b0;
        regdst   = 2'b00;
        wbsel    = 2'b00;
        illegal  = 1'b0;
        case (cur)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    irwrite = 1'b1;
                    pcen    = 1'b1;
                    alusrcb = 2'b01;
                end
            end
            S_DECODE: alusrcb = 2'b11;
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            S_MEMWB: begin
                regwrite = 1'b1;
                wbsel    = 2'b01;
            end
            S_MEMWR: begin
                mem_req  = 1'b1;
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_REXEC: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            S_IEXEC: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                aluop   = is_subi ? 2'b11 : 2'b00;
            end
            S_ALUWB: begin
                regwrite = 1'b1;
                regdst   = is_rtype ? 2'b01 : 2'b00;
            end
            S_BRANCH: begin
                alusrca = 1'b1;
                aluop   = 2'b11;
                pcsrc   = 2'b01;
                pcen    = is_bne ? ~zero : zero;
            end
            S_JUMP: begin
                pcsrc = 2'b10;
                pcen  = 1'b1;
            end
            S_JAL: begin
                pcsrc    = 2'b10;
                pcen     = 1'b1;
                regwrite = 1'b1;
                regdst   = 2'b10;
                wbsel    = 2'b10;
            end
            S_HALT:  illegal = 1'b1;
            default: ;
        endcase
        if (!reset_n) begin
            mem_req  = 1'b0;
            memwrite = 1'b0;
            irwrite  = 1'b0;
            pcen     = 1'b0;
            regwrite = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: builds the expected per-cycle control
// trace of each instruction from its opcode class and memory wait counts,
// then steps the DUT through it.
module tb_multicycle_ctrl;

    localparam logic [4:0] ADDI = 5'b11000;
    localparam logic [4:0] SUBI = 5'b11001;
    localparam logic [4:0] LW   = 5'b11010;
    localparam logic [4:0] SW   = 5'b11011;
    localparam logic [4:0] BEQ  = 5'b11100;
    localparam logic [4:0] BNE  = 5'b11101;
    localparam logic [4:0] J    = 5'b00000;
    localparam logic [4:0] JAL  = 5'b00111;

    typedef struct packed {
        logic       mem_req;
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       pcen;
        logic [1:0] pcsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic       regwrite;
        logic [1:0] regdst;
        logic [1:0] wbsel;
        logic       illegal;
        logic [3:0] st;
    } obs_t;

    // mode: 0 = drive mem_ready low, 1 = drive it high, 2 = random (ignored)
    typedef struct packed {
        obs_t       exp;
        logic [1:0] mode;
        logic       real_op;
    } ent_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [4:0] op;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, iord, memwrite, irwrite, pcen, alusrca, regwrite, illegal;
    logic [1:0] pcsrc, alusrcb, aluop, regdst, wbsel;
    logic [3:0] state;
    obs_t       obs;

    int checks = 0;
    int errors = 0;
    ent_t q[$];

    multicycle_ctrl dut (
        .clk(clk), .reset_n(reset_n), .op(op), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
        .pcen(pcen), .pcsrc(pcsrc), .alusrca(alusrca), .alusrcb(alusrcb),
        .aluop(aluop), .regwrite(regwrite), .regdst(regdst), .wbsel(wbsel),
        .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    assign obs = {mem_req, iord, memwrite, irwrite, pcen, pcsrc, alusrca, alusrcb,
                  aluop, regwrite, regdst, wbsel, illegal, state};

    task automatic add(input obs_t e, input logic [1:0] mode, input logic ro);
        ent_t n;
        n.exp = e;
        n.mode = mode;
        n.real_op = ro;
        q.push_back(n);
    endtask

    // Expected trace of one instruction: wf fetch wait cycles, wm data wait cycles.
    task automatic build(input logic [4:0] o, input logic z, input int wf, input int wm);
        obs_t e;
        q.delete();
        for (int i = 0; i < wf; i++) begin
            e = '0; e.mem_req = 1; add(e, 2'd0, 1'b0);
        end
        e = '0; e.mem_req = 1; e.irwrite = 1; e.pcen = 1; e.alusrcb = 2'b01;
        add(e, 2'd1, 1'b0);
        e = '0; e.st = 4'h1; e.alusrcb = 2'b11; add(e, 2'd2, 1'b1);
        casez (o)
            LW, SW: begin
                e = '0; e.st = 4'h2; e.alusrca = 1; e.alusrcb = 2'b10; add(e, 2'd2, 1'b1);
                e = '0; e.mem_req = 1; e.iord = 1;
                if (o == SW) begin
                    e.st = 4'h5; e.memwrite = 1;
                end else begin
                    e.st = 4'h3;
                end
                for (int i = 0; i < wm; i++) add(e, 2'd0, 1'b1);
                add(e, 2'd1, 1'b1);
                if (o == LW) begin
                    e = '0; e.st = 4'h4; e.regwrite = 1; e.wbsel = 2'b01; add(e, 2'd2, 1'b1);
                end
            end
            ADDI, SUBI: begin
                e = '0; e.st = 4'h7; e.alusrca = 1; e.alusrcb = 2'b10;
                e.aluop = (o == SUBI) ? 2'b11 : 2'b00; add(e, 2'd2, 1'b1);
                e = '0; e.st = 4'h8; e.regwrite = 1; add(e, 2'd2, 1'b1);
            end
            5'b01???: begin
                e = '0; e.st = 4'h6; e.alusrca = 1; e.aluop = 2'b10; add(e, 2'd2, 1'b1);
                e = '0; e.st = 4'h8; e.regwrite = 1; e.regdst = 2'b01; add(e, 2'd2, 1'b1);
            end
            BEQ, BNE: begin
                e = '0; e.st = 4'h9; e.alusrca = 1; e.aluop = 2'b11; e.pcsrc = 2'b01;
                e.pcen = (o == BNE) ? !z : z; add(e, 2'd2, 1'b1);
            end
            J: begin
                e = '0; e.st = 4'hA; e.pcsrc = 2'b10; e.pcen = 1; add(e, 2'd2, 1'b1);
            end
            JAL: begin
                e = '0; e.st = 4'hB; e.pcsrc = 2'b10; e.pcen = 1; e.regwrite = 1;
                e.regdst = 2'b10; e.wbsel = 2'b10; add(e, 2'd2, 1'b1);
            end
            default: begin
                e = '0; e.st = 4'hF; e.illegal = 1; add(e, 2'd2, 1'b1);
            end
        endcase
    endtask

    // Drive one cycle's inputs after the falling edge and sample settled outputs.
    task automatic step(input ent_t e, input logic [4:0] o, input logic z, output obs_t got);
        @(negedge clk);
        op = e.real_op ? o : 5'($urandom);
        zero = z;
        case (e.mode)
            2'd0:    mem_ready = 1'b0;
            2'd1:    mem_ready = 1'b1;
            default: mem_ready = 1'($urandom);
        endcase
        #1;
        got = obs;
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset_n = 1'b1;
        mem_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            op = 5'($urandom);
            zero = 1'($urandom);
            mem_ready = 1'b1;
            #1;
            checks++;
            if ({mem_req, memwrite, irwrite, pcen, regwrite, illegal, state} !== 10'd0) begin
                errors++;
                $display("FAIL reset_hold cyc%0d got strobes/illegal/state %b expected all 0", i,
                         {mem_req, memwrite, irwrite, pcen, regwrite, illegal, state});
            end
        end
        release_reset();
        #1;
        checks++;
        if (mem_req !== 1'b1 || state !== 4'h0) begin
            errors++;
            $display("FAIL reset_release got mem_req=%b state=%h expected mem_req=1 state=0",
                     mem_req, state);
        end
    endtask

    task automatic test_addi();
        obs_t got;
        logic z;
        z = 1'($urandom);
        build(ADDI, z, 0, 0);
        foreach (q[i]) begin
            step(q[i], ADDI, z, got);
            checks++;
            if (got !== q[i].exp) begin
                errors++;
                $display("FAIL addi cyc%0d got %h expected %h", i, got, q[i].exp);
            end
        end
    endtask

    task automatic test_lw_wait();
        obs_t got;
        int held;
        held = 0;
        build(LW, 1'b0, 0, 3);
        foreach (q[i]) begin
            step(q[i], LW, 1'b0, got);
            if (got.mem_req && got.iord) held++;
            checks++;
            if (got !== q[i].exp) begin
                errors++;
                $display("FAIL lw_wait cyc%0d got %h expected %h", i, got, q[i].exp);
            end
        end
        checks++;
        if (held !== 4) begin
            errors++;
            $display("FAIL lw_hold got %0d cycles of mem_req&iord expected 4", held);
        end
    endtask

    task automatic test_bne();
        obs_t got;
        for (int k = 0; k < 2; k++) begin
            build(BNE, (k == 0), $urandom_range(0, 2), 0);
            foreach (q[i]) begin
                step(q[i], BNE, (k == 0), got);
                checks++;
                if (got !== q[i].exp) begin
                    errors++;
                    $display("FAIL bne_z%0d cyc%0d got %h expected %h", (k == 0), i, got, q[i].exp);
                end
            end
        end
    endtask

    task automatic test_jal();
        obs_t got;
        build(JAL, 1'($urandom), 1, 0);
        foreach (q[i]) begin
            step(q[i], JAL, 1'b0, got);
            checks++;
            if (got !== q[i].exp) begin
                errors++;
                $display("FAIL jal cyc%0d got %h expected %h", i, got, q[i].exp);
            end
        end
    endtask

    task automatic test_random();
        obs_t got;
        logic [4:0] o;
        logic z;
        logic [4:0] legal [8];
        legal = '{ADDI, SUBI, LW, SW, BEQ, BNE, J, JAL};
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 8) == 8) o = {2'b01, 3'($urandom)};
            else                           o = legal[$urandom_range(0, 7)];
            z = 1'($urandom);
            build(o, z, $urandom_range(0, 3), $urandom_range(0, 3));
            foreach (q[i]) begin
                step(q[i], o, z, got);
                checks++;
                if (got !== q[i].exp) begin
                    errors++;
                    $display("FAIL random n%0d op=%b cyc%0d got %h expected %h", n, o, i, got, q[i].exp);
                end
            end
        end
    endtask

    task automatic test_illegal();
        obs_t got;
        ent_t halt;
        logic [4:0] o;
        for (int k = 0; k < 2; k++) begin
            o = (k == 0) ? 5'b10000 : {2'b10, 3'($urandom)};
            build(o, 1'b0, 0, 0);
            foreach (q[i]) begin
                step(q[i], o, 1'b0, got);
                checks++;
                if (got !== q[i].exp) begin
                    errors++;
                    $display("FAIL illegal_entry op=%b cyc%0d got %h expected %h", o, i, got, q[i].exp);
                end
            end
            halt = q[q.size() - 1];
            for (int i = 0; i < 20; i++) begin
                step(halt, o, 1'($urandom), got);
                checks++;
                if (got !== halt.exp) begin
                    errors++;
                    $display("FAIL illegal_hold cyc%0d got %h expected %h", i, got, halt.exp);
                end
            end
            @(negedge clk);
            reset_n = 1'b0;
            @(negedge clk);
            #1;
            checks++;
            if (state !== 4'h0 || illegal !== 1'b0) begin
                errors++;
                $display("FAIL illegal_reset got state=%h illegal=%b expected state=0 illegal=0",
                         state, illegal);
            end
            release_reset();
        end
    endtask

    task automatic test_reset_memwr();
        obs_t got;
        build(SW, 1'b0, 0, 5);
        for (int i = 0; i < 5; i++) begin
            step(q[i], SW, 1'b0, got);
            checks++;
            if (got !== q[i].exp) begin
                errors++;
                $display("FAIL memwr_pre cyc%0d got %h expected %h", i, got, q[i].exp);
            end
        end
        @(negedge clk);
        reset_n = 1'b0;
        mem_ready = 1'b0;
        #1;
        checks++;
        if (memwrite !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL memwr_gate got memwrite=%b mem_req=%b expected 0 0", memwrite, mem_req);
        end
        @(negedge clk);
        #1;
        checks++;
        if (state !== 4'h0 || memwrite !== 1'b0 || regwrite !== 1'b0 || pcen !== 1'b0) begin
            errors++;
            $display("FAIL memwr_reset got state=%h memwrite=%b regwrite=%b pcen=%b expected 0 0 0 0",
                     state, memwrite, regwrite, pcen);
        end
        release_reset();
    endtask

    initial begin
        reset_n = 1'b0;
        op = 5'd0;
        zero = 1'b0;
        mem_ready = 1'b0;
        test_reset();
        test_addi();
        test_lw_wait();
        test_bne();
        test_jal();
        test_random();
        test_illegal();
        test_reset_memwr();
        test_addi();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
